bist_march_gen: RTL and testbench



---
 rtl/bist_march_gen.sv | 117 +++++++++++
 tb/tb_bist_march_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_gen.sv
// March C- pattern generator: walks six elements over the whole memory, driving address/data/strobe and expected read data.
// Latency: first op registered one edge after BIST_START; no gap between elements; DONE entered one edge after the last op.
// Backpressure: none; the run advances every cycle and BIST_START is ignored while running.
module bist_march_gen #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CE,
    input  logic              rst,
    input  logic              BIST_START,
    output logic              BIST_EN,
    output logic [2:0]        BIST_MODE,
    output logic              en,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] IDATA,
    output logic [DATA_W-1:0] ANSWER,
    output logic              BIST_DONE
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    logic              phase;      // 0 = read op, 1 = write op of a two-op element

    logic              cur_up, cur_two, last_addr, elem_end, run_end;
    logic [2:0]        nxt_mode;
    logic              nxt_up, nxt_two, nxt_phase, nxt_wr, nxt_pat;
    logic [ADDR_W-1:0] nxt_addr;

    function automatic logic is_up(input logic [2:0] m);
        return !(m == 3'd4 || m == 3'd5);
    endfunction

    function automatic logic is_two(input logic [2:0] m);
        return (m >= 3'd2) && (m <= 3'd5);
    endfunction

    always_comb begin
        cur_up    = is_up(BIST_MODE);
        cur_two   = is_two(BIST_MODE);
        // terminal address is compared explicitly, never detected by counter wrap
        last_addr = cur_up ? (ADDR == ADDR_MAX) : (ADDR == '0);
        elem_end  = last_addr && (!cur_two || phase);
        run_end   = elem_end && (BIST_MODE == 3'd6);
        nxt_mode  = elem_end ? BIST_MODE + 3'd1 : BIST_MODE;
        nxt_up    = is_up(nxt_mode);
        nxt_two   = is_two(nxt_mode);
        nxt_phase = !elem_end && cur_two && !phase;
        if (elem_end)
            nxt_addr = nxt_up ? '0 : ADDR_MAX;
        else if (cur_two && !phase)
            nxt_addr = ADDR;
        else
            nxt_addr = cur_up ? ADDR + 1'b1 : ADDR - 1'b1;
        nxt_wr    = (nxt_mode == 3'd1) || (nxt_two && nxt_phase);
        // elements 2/4 are r0,w1 and 3/5 are r1,w0; 1 and 6 use the zero pattern
        if (nxt_mode == 3'd2 || nxt_mode == 3'd4)
            nxt_pat = nxt_phase;
        else if (nxt_mode == 3'd3 || nxt_mode == 3'd5)
            nxt_pat = !nxt_phase;
        else
            nxt_pat = 1'b0;
    end

    always_ff @(posedge CE) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            BIST_EN   <= 1'b0;
            BIST_MODE <= 3'd0;
            en        <= 1'b1;
            ADDR      <= '0;
            IDATA     <= '0;
            ANSWER    <= '0;
            BIST_DONE <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (BIST_START) begin
                        state     <= S_RUN;
                        phase     <= 1'b0;
                        BIST_EN   <= 1'b1;
                        BIST_MODE <= 3'd1;
                        en        <= 1'b1;
                        ADDR      <= '0;
                        IDATA     <= '0;
                        BIST_DONE <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (run_end) begin
                        // mode and address hold so the comparator's sticky flag survives
                        state     <= S_DONE;
                        BIST_EN   <= 1'b0;
                        en        <= 1'b1;
                        BIST_DONE <= 1'b1;
                    end else begin
                        BIST_MODE <= nxt_mode;
                        phase     <= nxt_phase;
                        ADDR      <= nxt_addr;
                        en        <= nxt_wr;
                        if (nxt_wr) begin
                            IDATA <= {DATA_W{nxt_pat}};
                        end else begin
                            IDATA  <= '0;
                            ANSWER <= {DATA_W{nxt_pat}};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_march_gen.sv
// Bench for bist_march_gen: op-list reference model, fixed-cycle vector table, DONE/restart/reset sequences.
module tb_bist_march_gen;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam int RUN_LEN = 10 * N;

    logic          CE = 1'b0;
    logic          rst;
    logic          BIST_START;
    logic          BIST_EN;
    logic [2:0]    BIST_MODE;
    logic          en;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] IDATA;
    logic [DW-1:0] ANSWER;
    logic          BIST_DONE;

    bist_march_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CE(CE), .rst(rst), .BIST_START(BIST_START), .BIST_EN(BIST_EN),
        .BIST_MODE(BIST_MODE), .en(en), .ADDR(ADDR), .IDATA(IDATA),
        .ANSWER(ANSWER), .BIST_DONE(BIST_DONE)
    );

    always #5 CE = ~CE;

    typedef struct packed {
        logic          bist_en;
        logic [2:0]    mode;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] idata;
        logic [DW-1:0] answer;
        logic          done;
    } obs_t;

    typedef struct {
        int    mode;
        int    addr;
        bit    wr;
        bit    pat;
    } op_t;

    typedef struct {
        string name;
        int    cyc;
        obs_t  exp;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    op_t           ops[$];
    obs_t          hist[RUN_LEN];
    vec_t          vecs[$];
    logic [DW-1:0] model_ans;

    function automatic obs_t cur();
        obs_t o;
        o.bist_en = BIST_EN; o.mode = BIST_MODE; o.we = en; o.addr = ADDR;
        o.idata = IDATA; o.answer = ANSWER; o.done = BIST_DONE;
        return o;
    endfunction

    function automatic obs_t mk(bit be, int m, bit w, int a, int id, int an, bit d);
        obs_t o;
        o.bist_en = be; o.mode = 3'(m); o.we = w; o.addr = AW'(a);
        o.idata = DW'(id); o.answer = DW'(an); o.done = d;
        return o;
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual{en,mode,we,addr,idata,ans,done}=%0b,%0d,%0b,%0d,%h,%h,%0b required=%0b,%0d,%0b,%0d,%h,%h,%0b",
                     nm, act.bist_en, act.mode, act.we, act.addr, act.idata, act.answer, act.done,
                     exp.bist_en, exp.mode, exp.we, exp.addr, exp.idata, exp.answer, exp.done);
        end
    endtask

    task automatic step();
        @(posedge CE);
        #1;
    endtask

    // March C- written as a flat list of operations, element by element
    task automatic push(input int m, input int a, input bit w, input bit p);
        op_t o;
        o.mode = m; o.addr = a; o.wr = w; o.pat = p;
        ops.push_back(o);
    endtask

    task automatic build_ops();
        for (int e = 1; e <= 6; e++) begin
            for (int i = 0; i < N; i++) begin
                int a;
                a = (e == 4 || e == 5) ? N - 1 - i : i;
                case (e)
                    1: push(e, a, 1'b1, 1'b0);
                    2, 4: begin push(e, a, 1'b0, 1'b0); push(e, a, 1'b1, 1'b1); end
                    3, 5: begin push(e, a, 1'b0, 1'b1); push(e, a, 1'b1, 1'b0); end
                    default: push(e, a, 1'b0, 1'b0);
                endcase
            end
        end
    endtask

    function automatic obs_t done_exp();
        return mk(1'b0, 6, 1'b1, N - 1, 0, int'(model_ans), 1'b1);
    endfunction

    function automatic obs_t idle_exp();
        return mk(1'b0, 0, 1'b1, 0, 0, 0, 1'b0);
    endfunction

    // Full run from IDLE/DONE; BIST_START either held high or randomized during the run
    task automatic run_full(input bit hold, input bit rec);
        obs_t e;
        BIST_START = 1'b1;
        step();
        for (int c = 0; c < RUN_LEN; c++) begin
            e = '0;
            e.bist_en = 1'b1;
            e.mode    = 3'(ops[c].mode);
            e.we      = ops[c].wr;
            e.addr    = AW'(ops[c].addr);
            if (ops[c].wr) begin
                e.idata = {DW{ops[c].pat}};
            end else begin
                e.idata   = '0;
                model_ans = {DW{ops[c].pat}};
            end
            e.answer = model_ans;
            chk($sformatf("run_c%0d", c), cur(), e);
            if (rec) hist[c] = cur();
            BIST_START = hold ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        BIST_START = 1'b0;
        chk("done_entry", cur(), done_exp());
    endtask

    initial begin
        int stop;
        rst = 1'b1;
        BIST_START = 1'b0;
        model_ans = '0;
        build_ops();
        checks++;
        if (ops.size() != RUN_LEN) begin
            errors++;
            $display("FAIL model_len actual=%0d required=%0d", ops.size(), RUN_LEN);
        end

        vecs.push_back('{"c0_elem1",     0,    mk(1'b1, 1, 1'b1, 0,   0,    0,    1'b0)});
        vecs.push_back('{"c255_elem1",   255,  mk(1'b1, 1, 1'b1, 255, 0,    0,    1'b0)});
        vecs.push_back('{"c256_elem2",   256,  mk(1'b1, 2, 1'b0, 0,   0,    0,    1'b0)});
        vecs.push_back('{"e2_a5_read",   266,  mk(1'b1, 2, 1'b0, 5,   0,    0,    1'b0)});
        vecs.push_back('{"e2_a5_write",  267,  mk(1'b1, 2, 1'b1, 5,   'hFF, 0,    1'b0)});
        vecs.push_back('{"c768_elem3",   768,  mk(1'b1, 3, 1'b0, 0,   0,    'hFF, 1'b0)});
        vecs.push_back('{"c1280_elem4",  1280, mk(1'b1, 4, 1'b0, 255, 0,    0,    1'b0)});
        vecs.push_back('{"e4_last_op",   1791, mk(1'b1, 4, 1'b1, 0,   'hFF, 0,    1'b0)});
        vecs.push_back('{"c1792_elem5",  1792, mk(1'b1, 5, 1'b0, 255, 0,    'hFF, 1'b0)});
        vecs.push_back('{"c2304_elem6",  2304, mk(1'b1, 6, 1'b0, 0,   0,    0,    1'b0)});
        vecs.push_back('{"c2559_last",   2559, mk(1'b1, 6, 1'b0, 255, 0,    0,    1'b0)});

        step();
        step();
        chk("reset_values", cur(), idle_exp());
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_hold", cur(), idle_exp());
        end

        run_full(1'b0, 1'b1);
        foreach (vecs[i]) chk(vecs[i].name, hist[vecs[i].cyc], vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            step();
            chk("done_hold", cur(), done_exp());
        end

        // restart from DONE with BIST_START held high for the whole run
        run_full(1'b1, 1'b0);
        step();
        chk("done_after_held_start", cur(), done_exp());

        // restart, then reset somewhere inside element 3 with BIST_START also high
        stop = $urandom_range(3 * N, 5 * N - 1);
        BIST_START = 1'b1;
        step();
        BIST_START = 1'b0;
        for (int c = 0; c < stop; c++) step();
        chk("pre_reset_pos", cur(),
            mk(1'b1, ops[stop].mode, ops[stop].wr, ops[stop].addr,
               ops[stop].wr ? {DW{ops[stop].pat}} : 0, cur().answer, 1'b0));
        rst = 1'b1;
        BIST_START = 1'b1;
        step();
        model_ans = '0;
        chk("midrun_reset_1", cur(), idle_exp());
        step();
        chk("midrun_reset_2", cur(), idle_exp());
        rst = 1'b0;
        BIST_START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_reset_idle", cur(), idle_exp());
        end

        BIST_START = 1'b1;
        step();
        BIST_START = 1'b0;
        chk("start_after_reset", cur(), mk(1'b1, 1, 1'b1, 0, 0, 0, 1'b0));
        step();
        chk("start_after_reset_c1", cur(), mk(1'b1, 1, 1'b1, 1, 0, 0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
